vga_timing: RTL and testbench

//  Free-running VGA raster timing generator, 800x600@60 Hz SVGA from a 40 MHz pixel clock.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_counter.sv | 33 +++
 rtl/vga_timing.sv | 87 ++++++++
 tb/tb_vga_timing.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared SVGA 800x600@60 raster timing constants, used as defaults by the timing
// generator and by downstream pipeline stages.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 600;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 23;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

endpackage

// File: rtl/vga_counter.sv
// Modulo-N counter with enable. wrap flags the enabled cycle in which count returns to 0.
module vga_counter
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // The counter width is fixed, so any modulus it cannot represent is a build error.
  if (N < 2 || N > (2 ** CNT_W)) begin : g_range_check
    $error("vga_counter: modulus N=%0d does not fit in %0d bits", N, CNT_W);
  end

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: pixel/line counters plus registered sync,
// blanking and frame-start strobes, all aligned to the hcount/vcount of the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int       H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int       H_FP     = vga_pkg::H_FP,
  parameter int       H_SYNC   = vga_pkg::H_SYNC,
  parameter int       H_BP     = vga_pkg::H_BP,
  parameter int       V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int       V_FP     = vga_pkg::V_FP,
  parameter int       V_SYNC   = vga_pkg::V_SYNC,
  parameter int       V_BP     = vga_pkg::V_BP,
  parameter bit       SYNC_POL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HBLNK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HSYNC_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HSYNC_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VBLNK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VSYNC_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VSYNC_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (LINE_TOTAL > 2048 || FRAME_LINES > 2048) begin : g_total_check
    $error("vga_timing: totals %0d x %0d exceed 11-bit counters", LINE_TOTAL, FRAME_LINES);
  end

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             at_origin;

  vga_counter #(.N(LINE_TOTAL)) u_hcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (h_next),
    .wrap  (h_wrap)
  );

  vga_counter #(.N(FRAME_LINES)) u_vcnt (
    .clk   (clk),
    .rst   (rst),
    .en    (h_wrap),
    .count (v_next),
    .wrap  (v_wrap)
  );

  // The counters run one cycle ahead of the outputs; at_origin marks the cycle in which
  // they sit at (0,0), which only happens right after reset or a full-frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
      at_origin   <= 1'b1;
    end else begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= ((h_next >= HSYNC_START) && (h_next < HSYNC_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((v_next >= VSYNC_START) && (v_next < VSYNC_END)) ? SYNC_POL : ~SYNC_POL;
      hblnk       <= (h_next >= HBLNK_START);
      vblnk       <= (v_next >= VBLNK_START);
      frame_start <= at_origin;
      at_origin   <= v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: SVGA instance plus two shrunken rasters (both sync polarities),
// compared every cycle against a raster position model derived from elapsed cycles.
module tb_vga_timing;

  // Shrunken raster so whole frames, corners and vsync fit in a short run.
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [10:0] f_hc, f_vc, s_hc, s_vc, n_hc, n_vc;
  logic        f_hs, f_vs, f_hb, f_vb, f_fs;
  logic        s_hs, s_vs, s_hb, s_vb, s_fs;
  logic        n_hs, n_vs, n_hb, n_vb, n_fs;

  int test_count = 0;
  int fail_count = 0;

  int  t           = 0;
  bit  rst_state   = 1'b1;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  vga_timing u_full (
    .clk(clk), .rst(rst), .hcount(f_hc), .vcount(f_vc), .hsync(f_hs), .vsync(f_vs),
    .hblnk(f_hb), .vblnk(f_vb), .frame_start(f_fs)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b1)
  ) u_small (
    .clk(clk), .rst(rst), .hcount(s_hc), .vcount(s_vc), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .frame_start(s_fs)
  );

  vga_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1'b0)
  ) u_neg (
    .clk(clk), .rst(rst), .hcount(n_hc), .vcount(n_vc), .hsync(n_hs), .vsync(n_vs),
    .hblnk(n_hb), .vblnk(n_vb), .frame_start(n_fs)
  );

  // Reference: t counts cycles since the outputs first showed (0,0) after reset.
  always @(posedge clk) begin
    if (rst) begin
      rst_state   = 1'b1;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (rst_state) t = 0;
      else t = t + 1;
      rst_state = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    test_count++;
    if (observed != expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic checkDut(input string name,
                          input int ha, input int hf, input int hs, input int hb,
                          input int va, input int vf, input int vs, input int vb,
                          input bit pol, input logic [10:0] hc, input logic [10:0] vc,
                          input logic hsy, input logic vsy, input logic hbl,
                          input logic vbl, input logic fs);
    int ht, vt, h, v;
    bit e_hs, e_vs, e_hb, e_vb, e_fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    if (rst_state) begin
      h = 0; v = 0; e_hs = !pol; e_vs = !pol; e_hb = 0; e_vb = 0; e_fs = 0;
    end else begin
      h    = t % ht;
      v    = (t / ht) % vt;
      e_hb = (h >= ha);
      e_vb = (v >= va);
      e_hs = ((h >= ha + hf) && (h < ha + hf + hs)) ? pol : !pol;
      e_vs = ((v >= va + vf) && (v < va + vf + vs)) ? pol : !pol;
      e_fs = (h == 0) && (v == 0);
    end
    checkOutput({name, ".hcount"}, int'(hc), h);
    checkOutput({name, ".vcount"}, int'(vc), v);
    checkOutput({name, ".hsync"}, int'(hsy), int'(e_hs));
    checkOutput({name, ".vsync"}, int'(vsy), int'(e_vs));
    checkOutput({name, ".hblnk"}, int'(hbl), int'(e_hb));
    checkOutput({name, ".vblnk"}, int'(vbl), int'(e_vb));
    checkOutput({name, ".frame_start"}, int'(fs), int'(e_fs));
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkDut("full", 800, 40, 128, 88, 600, 1, 4, 23, 1'b1,
               f_hc, f_vc, f_hs, f_vs, f_hb, f_vb, f_fs);
      checkDut("small", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1,
               s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_fs);
      checkDut("neg", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0,
               n_hc, n_vc, n_hs, n_vs, n_hb, n_vb, n_fs);
    end
  end

  task automatic applyStimulus(input bit r, input int cycles);
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int n, hs_cnt, first_hb, v0, period, vs_cnt, nvs_cnt;

    // Reset held for three clocks, then the first cycle must be the frame origin.
    applyStimulus(1'b1, 3);
    checkOutput("reset.full_hsync", int'(f_hs), 0);
    checkOutput("reset.neg_vsync", int'(n_vs), 1);
    applyStimulus(1'b0, 1);
    checkOutput("release.frame_start", int'(f_fs), 1);
    checkOutput("release.hcount", int'(f_hc), 0);

    // One SVGA line: blank edge, sync width and the line wrap.
    n = 0;
    while (f_hc != 11'd0 && n < 2000) begin @(negedge clk); n++; end
    checkOutput("line.start_found", int'(n < 2000), 1);
    v0 = int'(f_vc);
    hs_cnt = 0;
    first_hb = -1;
    for (int i = 0; i < 1056; i++) begin
      if (f_hs) hs_cnt++;
      if (f_hb && first_hb < 0) first_hb = int'(f_hc);
      @(negedge clk);
    end
    checkOutput("line.hsync_width", hs_cnt, 128);
    checkOutput("line.hblnk_rise", first_hb, 800);
    checkOutput("line.wrap_hcount", int'(f_hc), 0);
    checkOutput("line.wrap_vcount", int'(f_vc), v0 + 1);

    // Whole small frame: period between frame starts and vsync duration for both polarities.
    n = 0;
    while (!s_fs && n < 1000) begin @(negedge clk); n++; end
    checkOutput("frame.start_found", int'(n < 1000), 1);
    period = 0; vs_cnt = 0; nvs_cnt = 0;
    do begin
      @(negedge clk);
      period++;
      if (s_vs) vs_cnt++;
      if (n_vs) nvs_cnt++;
    end while (!s_fs && period < 1000);
    checkOutput("frame.period", period, S_HT * S_VT);
    checkOutput("frame.vsync_cycles", vs_cnt, S_VS * S_HT);
    checkOutput("frame.neg_vsync_high", nvs_cnt, (S_VT - S_VS) * S_HT);

    // Corner: last pixel of the last line rolls straight into the next frame origin.
    n = 0;
    while (!(int'(s_hc) == S_HT - 1 && int'(s_vc) == S_VT - 1) && n < 1000) begin
      @(negedge clk); n++;
    end
    checkOutput("corner.found", int'(n < 1000), 1);
    @(negedge clk);
    checkOutput("corner.origin", int'({s_hc, s_vc}), 0);
    checkOutput("corner.blanks", int'({s_hb, s_vb}), 0);
    checkOutput("corner.frame_start", int'(s_fs), 1);

    // One-cycle reset in the middle of a frame.
    n = 0;
    while (!(s_hc == 11'd12 && s_vc == 11'd7) && n < 1000) begin @(negedge clk); n++; end
    checkOutput("midreset.found", int'(n < 1000), 1);
    applyStimulus(1'b1, 1);
    checkOutput("midreset.hcount", int'(s_hc), 0);
    checkOutput("midreset.frame_start", int'(s_fs), 0);
    checkOutput("midreset.neg_hsync", int'(n_hs), 1);
    applyStimulus(1'b0, 1);
    checkOutput("midreset.restart_fs", int'(s_fs), 1);
    applyStimulus(1'b0, 1);
    checkOutput("midreset.restart_h", int'(s_hc), 1);

    // Random run lengths and reset pulses; the per-cycle monitor does the checking.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, int'($urandom_range(1, 1500)));
      applyStimulus(1'b1, int'($urandom_range(1, 3)));
    end
    applyStimulus(1'b0, 2500);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
